// File: rtl/uart_tx_frame_pkg.sv
// rtl/uart_tx_frame_pkg.sv - shared UART framing state encodings and line constants
package uart_tx_frame_pkg;

  // Frame FSM encodings, shared with the receive side
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  // Level of an idle (marking) serial line
  localparam logic UART_LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter producing a tick on the last cycle of each bit
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic TX_CLK,
  input  logic TX_RST,
  input  logic enable_i,
  output logic bit_tick_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick on the final cycle of a bit; hold the count at zero while idle so frames start phase-aligned
  always_comb begin
    bit_tick_o = enable_i && (cnt_q == CNT_LAST);
    cnt_d      = cnt_q;
    if (!enable_i || bit_tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Tick counter register
  always_ff @(posedge TX_CLK or posedge TX_RST) begin
    if (TX_RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame transmitter; parity bit enabled by `UART_TX_PARITY_EN
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_WIDTH   = `DATA_WIDTH,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                  TX_CLK,
  input  logic                  TX_RST,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  TX_START,
  output logic                  TX_READY,
  output logic                  TX_DONE,
  output logic                  TX_DATA
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  stop_q, stop_d;
  logic                  bit_tick;
  logic                  baud_en;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`else
  logic                  unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  assign baud_en = (state_q != S_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .TX_CLK    (TX_CLK),
    .TX_RST    (TX_RST),
    .enable_i  (baud_en),
    .bit_tick_o(bit_tick)
  );

  // Frame sequencing: next state, shift/bit/stop counters and line level
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    TX_DATA  = UART_LINE_IDLE;
    TX_READY = 1'b0;
    TX_DONE  = 1'b0;
    case (state_q)
      S_IDLE: begin
        TX_READY = 1'b1;
        if (TX_START) begin
          shift_d  = DATA_IN;
          idx_d    = '0;
          stop_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
          // Parity comes from the accepted word, not the shifting copy
          parity_d = (^DATA_IN) ^ PARITY_ODD;
`endif
          state_d  = S_START;
        end
      end
      S_START: begin
        TX_DATA = 1'b0;
        if (bit_tick) state_d = S_DATA;
      end
      S_DATA: begin
        TX_DATA = shift_q[0];
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        TX_DATA = parity_q;
        if (bit_tick) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        TX_DATA = 1'b1;
        if (bit_tick) begin
          if (stop_q == LAST_STOP) begin
            TX_DONE = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight
  always_ff @(posedge TX_CLK or posedge TX_RST) begin
    if (TX_RST) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed table-driven bench for uart_tx_frame
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic [6:0] data_c = '0;
  logic       tx_a, rdy_a, done_a;
  logic       tx_b, rdy_b, done_b;
  logic       tx_c, rdy_c, done_c;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(1'b0)) dut_a (
    .TX_CLK(clk), .TX_RST(rst), .DATA_IN(data_a), .TX_START(start_a),
    .TX_READY(rdy_a), .TX_DONE(done_a), .TX_DATA(tx_a));

  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(1'b1)) dut_b (
    .TX_CLK(clk), .TX_RST(rst), .DATA_IN(data_b), .TX_START(start_b),
    .TX_READY(rdy_b), .TX_DONE(done_b), .TX_DATA(tx_b));

  uart_tx_frame #(.DATA_WIDTH(7), .CLKS_PER_BIT(2), .STOP_BITS(2), .PARITY_ODD(1'b0)) dut_c (
    .TX_CLK(clk), .TX_RST(rst), .DATA_IN(data_c), .TX_START(start_c),
    .TX_READY(rdy_c), .TX_DONE(done_c), .TX_DATA(tx_c));

  typedef struct {
    int          sel;
    logic [8:0]  data;
    logic [15:0] bits;
    int          len;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

`ifdef UART_TX_PARITY_EN
  localparam int          FLEN = 44;
  localparam logic [15:0] B2B1 = 16'h04AA;
  localparam logic [15:0] B2B2 = 16'h0554;
  localparam logic [15:0] A5F  = 16'h054A;
`else
  localparam int          FLEN = 40;
  localparam logic [15:0] B2B1 = 16'h02AA;
  localparam logic [15:0] B2B2 = 16'h0354;
  localparam logic [15:0] A5F  = 16'h034A;
`endif

  function automatic logic [2:0] obs(int sel);
    case (sel)
      0:       return {tx_a, done_a, rdy_a};
      1:       return {tx_b, done_b, rdy_b};
      default: return {tx_c, done_c, rdy_c};
    endcase
  endfunction

  task automatic check(string name, int k, logic [2:0] got, logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got {tx,done,ready}=%b expected %b", name, k, got, exp);
    end
  endtask

  task automatic drive(int sel, logic st, logic [8:0] d);
    case (sel)
      0:       begin start_a = st; data_a = d[7:0]; end
      1:       begin start_b = st; data_b = d[7:0]; end
      default: begin start_c = st; data_c = d[6:0]; end
    endcase
  endtask

  task automatic run_frame(string name, int sel, logic [8:0] d, logic [15:0] bits, int len, bit glitch);
    int cpb;
    logic [2:0] exp;
    cpb = (sel == 2) ? 2 : 4;
    @(negedge clk);
    check({name, "_pre"}, 0, obs(sel), 3'b101);
    drive(sel, 1'b1, d);
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      if (k <= len) exp = {bits[(k-1)/cpb], (k == len), 1'b0};
      else          exp = 3'b101;
      check(name, k, obs(sel), exp);
      if (k == 1) drive(sel, 1'b0, ~d);
      if (glitch && k == 10) drive(sel, 1'b1, 9'h03C);
      if (glitch && k == 11) drive(sel, 1'b0, 9'h03C);
    end
    if (glitch) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        check({name, "_no_queue"}, len + 2 + j, obs(sel), 3'b101);
      end
    end
  endtask

  initial begin
    logic [2:0] exp;
    int ndone;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{0, 9'h0A5, 16'h054A, 44};
    vecs[1] = '{0, 9'h000, 16'h0400, 44};
    vecs[2] = '{0, 9'h0FF, 16'h05FE, 44};
    vecs[3] = '{0, 9'h055, 16'h04AA, 44};
    vecs[4] = '{1, 9'h001, 16'h0402, 44};
    vecs[5] = '{2, 9'h041, 16'h0682, 22};
    vecs[6] = '{2, 9'h07F, 16'h07FE, 22};
`else
    vecs[0] = '{0, 9'h0A5, 16'h034A, 40};
    vecs[1] = '{0, 9'h000, 16'h0200, 40};
    vecs[2] = '{0, 9'h0FF, 16'h03FE, 40};
    vecs[3] = '{0, 9'h055, 16'h02AA, 40};
    vecs[4] = '{1, 9'h001, 16'h0202, 40};
    vecs[5] = '{2, 9'h041, 16'h0382, 20};
    vecs[6] = '{2, 9'h07F, 16'h03FE, 20};
`endif

    // Reset held with a pending request: line idle, ready, no done
    start_a = 1'b1;
    data_a  = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("reset_a", k, obs(0), 3'b101);
      check("reset_c", k, obs(2), 3'b101);
    end
    rst     = 1'b0;
    start_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_reset_idle", k, obs(0), 3'b101);
    end

    // Table of single frames
    for (int i = 0; i < 7; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].sel, vecs[i].data, vecs[i].bits, vecs[i].len, 1'b0);
    end

    // Request while busy is dropped
    run_frame("busy_ignore", 0, 9'h0A5, A5F, FLEN, 1'b1);

    // Back-to-back with TX_START held high
    ndone = 0;
    @(negedge clk);
    drive(0, 1'b1, 9'h055);
    for (int k = 1; k <= 2 * FLEN + 2; k++) begin
      @(negedge clk);
      if (k <= FLEN)              exp = {B2B1[(k-1)/4], (k == FLEN), 1'b0};
      else if (k == FLEN + 1)     exp = 3'b101;
      else if (k <= 2 * FLEN + 1) exp = {B2B2[(k-FLEN-2)/4], (k == 2 * FLEN + 1), 1'b0};
      else                        exp = 3'b101;
      check("b2b", k, obs(0), exp);
      if (done_a) ndone++;
      if (k == 1) drive(0, 1'b1, 9'h0AA);
      if (k == FLEN + 2) drive(0, 1'b0, 9'h0AA);
    end
    checks++;
    if (ndone != 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d expected 2", ndone);
    end

    // Reset during the fourth bit of a frame
    @(negedge clk);
    drive(0, 1'b1, 9'h0A5);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check("rst_mid_pre", k, obs(0), {A5F[(k-1)/4], 1'b0, 1'b0});
      if (k == 1) drive(0, 1'b0, 9'h0A5);
    end
    #2 rst = 1'b1;
    #1 check("rst_mid_async", 14, obs(0), 3'b101);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_mid_hold", k, obs(0), 3'b101);
    end
    rst = 1'b0;
    run_frame("after_rst", 0, 9'h0A5, A5F, FLEN, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
